// File: rtl/ntt_addr_seq.sv
// NTT butterfly address sequencer: walks LOGN stages of N/2 butterflies and
// emits operand addresses, twiddle index and stage with valid/ready handshake.
// Optional feature macro: ADDR_SEQ_STALL_CNT_EN adds a 16-bit stall_cnt output.
module ntt_addr_seq #(
  parameter int unsigned LOGN = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         inv,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [LOGN-1:0]              addr_a,
  output logic [LOGN-1:0]              addr_b,
  output logic [LOGN-2:0]              tw_idx,
  output logic [$clog2(LOGN+1)-1:0]    stage,
  output logic                         busy,
  output logic                         done
`ifdef ADDR_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int unsigned JW = LOGN - 1;
  localparam int unsigned SW = $clog2(LOGN + 1);
  localparam logic [JW-1:0] JMAX     = '1;
  localparam logic [SW-1:0] LAST_STG = SW'(LOGN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [SW-1:0]   stg_q, stg_d;
  logic            dir_q, dir_d;
  logic            accept;

  logic [SW-1:0]   sh_d;
  logic [LOGN-1:0] jx, mask, span, a_d, b_d;
  logic [JW-1:0]   tw_d;
  logic            run_d;

  // Next-state: butterfly/stage counters and pass control.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stg_d   = stg_q;
    dir_d   = dir_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          j_d     = '0;
          stg_d   = '0;
          dir_d   = inv;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (j_q == JMAX) begin
            j_d = '0;
            if (stg_q == LAST_STG) begin
              state_d = DONE;
              stg_d   = '0;
            end else begin
              stg_d = stg_q + SW'(1);
            end
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        j_d     = '0;
        stg_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address math for the next butterfly; span is always 2**sh_d.
  always_comb begin
    sh_d  = dir_d ? stg_d : (LAST_STG - stg_d);
    jx    = LOGN'(j_d);
    span  = LOGN'(1) << sh_d;
    mask  = span - LOGN'(1);
    a_d   = ((jx & ~mask) << 1) | (jx & mask);
    b_d   = a_d + span;
    tw_d  = JW'((jx & mask) << (LAST_STG - sh_d));
    run_d = (state_d == RUN);
  end

  // State and registered outputs; outputs read zero outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      j_q       <= '0;
      stg_q     <= '0;
      dir_q     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      tw_idx    <= '0;
      stage     <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      stg_q     <= stg_d;
      dir_q     <= dir_d;
      out_valid <= run_d;
      busy      <= run_d;
      done      <= (state_d == DONE);
      addr_a    <= run_d ? a_d   : '0;
      addr_b    <= run_d ? b_d   : '0;
      tw_idx    <= run_d ? tw_d  : '0;
      stage     <= run_d ? stg_d : '0;
    end
  end

`ifdef ADDR_SEQ_STALL_CNT_EN
  // Saturating count of RUN cycles where downstream holds off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if ((state_q == RUN) && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Testbench for ntt_addr_seq (LOGN=3): behavioural model plus literal sequences.
module tb_ntt_addr_seq;

  localparam int LOGN  = 3;
  localparam int N     = 8;
  localparam int HALF  = 4;
  localparam int TOTAL = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       inv = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] addr_a;
  logic [2:0] addr_b;
  logic [1:0] tw_idx;
  logic [1:0] stage;
  logic       busy;
  logic       done;
`ifdef ADDR_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ntt_addr_seq #(.LOGN(LOGN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inv       (inv),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
`ifdef ADDR_SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Pass-level model: transfer count k, direction, and phase flags.
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  bit m_dir = 1'b0;
  int m_k = 0;
  int m_stall = 0;

  int rec_a[$];
  int rec_b[$];
  int rec_tw[$];
  int done_cnt = 0;

  int fwd_a[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int fwd_b[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int fwd_tw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
  int inv_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int inv_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int inv_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Butterfly k of a pass, straight from the span/address formulas.
  function automatic void bfly(input int k, input bit d, output int a, output int b,
                               output int tw, output int s);
    int j;
    int span;
    s    = k / HALF;
    j    = k % HALF;
    span = d ? (1 << s) : (N >> (s + 1));
    a    = (j / span) * 2 * span + (j % span);
    b    = a + span;
    tw   = ((j % span) * (N / (2 * span))) % HALF;
  endfunction

  // Model update on each clock edge, async reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_done  <= 1'b0;
      m_dir   <= 1'b0;
      m_k     <= 0;
      m_stall <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_run) begin
      if (!out_ready) begin
        if (m_stall < 65535) m_stall <= m_stall + 1;
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == TOTAL) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end else if (start) begin
      m_run   <= 1'b1;
      m_k     <= 0;
      m_dir   <= inv;
      m_stall <= 0;
    end
  end

  // Per-cycle compare against the model, plus transfer/done recording.
  always @(negedge clk) begin
    int a, b, tw, s;
    if (m_run) begin
      bfly(m_k, m_dir, a, b, tw, s);
    end else begin
      a = 0; b = 0; tw = 0; s = 0;
    end
    chk("out_valid", int'(out_valid), int'(m_run));
    chk("busy", int'(busy), int'(m_run));
    chk("done", int'(done), int'(m_done));
    chk("addr_a", int'(addr_a), a);
    chk("addr_b", int'(addr_b), b);
    chk("tw_idx", int'(tw_idx), tw);
    chk("stage", int'(stage), s);
`ifdef ADDR_SEQ_STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), m_stall);
`endif
    if (out_valid && out_ready) begin
      rec_a.push_back(int'(addr_a));
      rec_b.push_back(int'(addr_b));
      rec_tw.push_back(int'(tw_idx));
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    rec_a.delete();
    rec_b.delete();
    rec_tw.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input bit d);
    start = 1'b1;
    inv   = d;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int n);
    int t = 0;
    while (rec_a.size() < n && t < 300) begin
      tick();
      t++;
    end
    if (rec_a.size() < n) chk("wait_xfers_timeout", rec_a.size(), n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((m_run || m_done) && t < 300) begin
      tick();
      t++;
    end
    if (m_run || m_done) chk("wait_idle_timeout", t, 0);
  endtask

  task automatic check_seq(input string tag, input bit d);
    chk({tag, "_count"}, rec_a.size(), TOTAL);
    for (int i = 0; i < TOTAL; i++) begin
      if (i < rec_a.size()) begin
        chk({tag, "_a"},  rec_a[i],  d ? inv_a[i]  : fwd_a[i]);
        chk({tag, "_b"},  rec_b[i],  d ? inv_b[i]  : fwd_b[i]);
        chk({tag, "_tw"}, rec_tw[i], d ? inv_tw[i] : fwd_tw[i]);
      end
    end
  endtask

  initial begin
    bit d;
    int t;
    out_ready = 1'b1;
    #22 rst_n = 1'b1;
    tick();

    // Forward pass, no backpressure.
    clear_rec();
    do_start(1'b0);
    wait_idle();
    check_seq("fwd", 1'b0);
    chk("fwd_done_pulses", done_cnt, 1);

    // Inverse pass.
    clear_rec();
    do_start(1'b1);
    wait_idle();
    check_seq("inv", 1'b1);
    chk("inv_done_pulses", done_cnt, 1);

    // Backpressure: hold off 5 cycles at stage 1, j 2.
    clear_rec();
    do_start(1'b0);
    wait_xfers(6);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_addr_a", int'(addr_a), 4);
    chk("bp_addr_b", int'(addr_b), 6);
    chk("bp_tw", int'(tw_idx), 0);
    chk("bp_stage", int'(stage), 1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    check_seq("bp", 1'b0);
`ifdef ADDR_SEQ_STALL_CNT_EN
    chk("bp_stall_cnt", int'(stall_cnt), 5);
`endif

    // start and inv toggled during RUN, random ready.
    clear_rec();
    do_start(1'b0);
    t = 0;
    while (m_run && t < 300) begin
      start     = 1'($urandom % 2);
      inv       = 1'($urandom % 2);
      out_ready = ($urandom % 4) != 0;
      tick();
      t++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    check_seq("toggle", 1'b0);
    chk("toggle_done_pulses", done_cnt, 1);

    // Reset after the 7th transfer.
    clear_rec();
    do_start(1'b0);
    wait_xfers(7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr_a", int'(addr_a), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_no_done", done_cnt, 0);
    clear_rec();
    do_start(1'b0);
    wait_xfers(1);
    if (rec_a.size() > 0) begin
      chk("rst_first_a", rec_a[0], 0);
      chk("rst_first_b", rec_b[0], 4);
      chk("rst_first_tw", rec_tw[0], 0);
    end
    wait_idle();

    // start in the DONE cycle is ignored; one cycle later it is taken.
    clear_rec();
    do_start(1'b0);
    t = 0;
    while (!m_done && t < 300) begin
      tick();
      t++;
    end
    if (!m_done) chk("done_wait_timeout", t, 0);
    start = 1'b1;
    inv   = 1'b0;
    tick();
    chk("done_start_ignored", int'(out_valid), 0);
    tick();
    start = 1'b0;
    chk("idle_start_taken", int'(out_valid), 1);
    chk("idle_start_a", int'(addr_a), 0);
    chk("idle_start_b", int'(addr_b), 4);
    wait_idle();

    // Randomized passes with random direction and backpressure.
    for (int i = 0; i < 6; i++) begin
      clear_rec();
      d = 1'($urandom % 2);
      do_start(d);
      t = 0;
      while (m_run && t < 300) begin
        out_ready = $urandom_range(0, 2) != 0;
        tick();
        t++;
      end
      out_ready = 1'b1;
      wait_idle();
      check_seq("rand", d);
      chk("rand_done_pulses", done_cnt, 1);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ntt_addr_seq.md
NTT_ADDR_SEQ -- requirements
Module: ntt_addr_seq

Interface
REQ-001 SHALL have parameter LOGN, default 3, log2 of transform size N = 2**LOGN; legal range 2..12.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a new pass; accepted only in IDLE.
REQ-005 SHALL have port inv  input  1  0 = forward pass (span descending), 1 = inverse pass (span ascending); sampled when start is accepted.
REQ-006 SHALL have port out_ready  input  1  downstream accepts the current butterfly.
REQ-007 SHALL have port out_valid  output  1  addr_a/addr_b/tw_idx/stage are valid.
REQ-008 SHALL have port addr_a  output  LOGN  upper butterfly operand address.
REQ-009 SHALL have port addr_b  output  LOGN  lower butterfly operand address.
REQ-010 SHALL have port tw_idx  output  LOGN-1  twiddle table index.
REQ-011 SHALL have port stage  output  $clog2(LOGN+1)  current stage, 0..LOGN-1.
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port done  output  1  one-cycle pulse at pass completion.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on acceptance of the final butterfly; DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL ignore start in RUN and DONE, with no effect on the pass in progress.
REQ-016 SHALL latch inv into an internal direction register on start acceptance; inv changes during RUN SHALL have no effect.
REQ-017 SHALL assert out_valid in the cycle after start acceptance and hold it, together with stable outputs, for the whole of RUN.
REQ-018 SHALL advance to the next butterfly only on a cycle with out_valid && out_ready; no advance otherwise.
REQ-019 SHALL use butterfly index j from 0 to N/2-1 within each stage; stage from 0 to LOGN-1.
REQ-020 SHALL use span = N >> (stage+1) when the direction register is 0, and span = 1 << stage when it is 1.
REQ-021 SHALL drive addr_a = (j / span) * 2 * span + (j mod span), and addr_b = addr_a + span.
REQ-022 SHALL drive tw_idx = (j mod span) * (N / (2*span)), truncated to LOGN-1 bits.
REQ-023 SHALL wrap j to 0 and increment stage when a transfer accepts j = N/2-1; the final butterfly is j = N/2-1 at stage = LOGN-1.
REQ-024 SHALL complete a pass in exactly LOGN * N/2 accepted transfers.
REQ-025 SHALL deassert out_valid and busy in DONE and assert done for exactly that cycle.
REQ-026 SHALL drive addr_a, addr_b, tw_idx and stage to 0 in IDLE and DONE.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously enter IDLE and clear j, stage and the direction register; out_valid, busy and done SHALL be 0 and all address outputs SHALL be 0.
REQ-028 SHALL abandon any pass in progress on reset mid-RUN, with no done pulse; the first start after rst_n rises SHALL begin at stage 0, j 0.

Configuration
REQ-029 SHALL, with ADDR_SEQ_STALL_CNT_EN defined, add output port stall_cnt (16 bits).
REQ-030 SHALL have stall_cnt count cycles in RUN with out_valid && !out_ready; it SHALL clear to 0 on start acceptance and on reset, and saturate at 16'hFFFF.
REQ-031 SHALL, without ADDR_SEQ_STALL_CNT_EN, have neither the stall_cnt port nor the counter logic; all other behaviour SHALL be identical.

Verification (LOGN=3)
REQ-032 SHALL test forward pass, out_ready=1: (a,b,tw) = (0,4,0),(1,5,1),(2,6,2),(3,7,3), then (0,2,0),(1,3,2),(4,6,0),(5,7,2), then (0,1,0),(2,3,0),(4,5,0),(6,7,0); done pulses the cycle after the 12th transfer.
REQ-033 SHALL test inverse pass: first transfers are (0,1,0),(2,3,0); stage 1 starts with (0,2,0),(1,3,2); stage 2 is (0,4,0)..(3,7,3); total 12 transfers.
REQ-034 SHALL test backpressure by holding out_ready=0 for 5 cycles at j=2, stage 1: outputs hold at (4,6,0) and stage=1; with macro defined, stall_cnt=5 at the end of the pass.
REQ-035 SHALL test start pulsed and inv toggled mid-RUN: the sequence is unchanged and there is exactly one done pulse.
REQ-036 SHALL test rst_n low after the 7th transfer: out_valid=0 and busy=0 immediately, and there is no done pulse; a subsequent start yields (0,4,0) first.
REQ-037 SHALL test start asserted in the DONE cycle: it is ignored, and a start one cycle later is accepted.
